ide_cmd_executor: RTL
=====================

// Module: ide_cmd_executor
// PURPOSE
//  Responder for the IDE command handshake: accepts one-cycle IDE_command strobes (LBA, sector count, nWR) and
//  holds IDE_busy for the whole transfer. Splits each command into device bursts of at most BURST_SECTORS.
//  Moves 16-bit words between the write/read FIFOs and the device data port, pausing on the FIFO level flags.
//  Sits between the IO controller and the ATA device-side engine.
// PARAMETERS
//  BURST_SECTORS  256  max sectors per device command (1..65536)
//  SECTOR_WORDS   256  16-bit words per sector
// PORTS
//  clk                 in   1   single clock
//  nRST                in   1   synchronous active-low reset
//  IDE_command         in   1   command strobe, sampled only in IDLE
//  IDE_LBA             in   48  start LBA
//  IDE_Sec_Count       in   17  sectors to move (0..0x1FFFF)
//  IDE_nWR             in   1   0 = write (wfifo->disk), 1 = read (disk->rfifo)
//  IDE_busy            out  1   high from accept until completion or abort
//  IDE_w_almost_empty  in   1   wfifo low: stop popping
//  IDE_r_almost_full   in   1   rfifo high: stop pushing
//  IDE_r_go_on         in   1   rfifo drained: resume pushing
//  wfifo_rdreq         out  1   pop strobe (show-ahead FIFO)
//  wfifo_q             in   16  wfifo head word
//  rfifo_wrreq         out  1   push strobe
//  rfifo_data          out  16  push data
//  dev_cmd_valid       out  1   burst command valid; held until dev_cmd_ready
//  dev_cmd_ready       in   1   device accepts burst command
//  dev_lba             out  48  burst start LBA
//  dev_count           out  17  burst sector count (1..BURST_SECTORS)
//  dev_write           out  1   burst direction, 1 = write
//  dev_wdata           out  16  write word (= wfifo_q)
//  dev_wvalid          out  1   write word valid
//  dev_wready          in   1   device takes write word
//  dev_rdata           in   16  read word
//  dev_rvalid          in   1   read word valid
//  dev_rready          out  1   executor takes read word
//  dev_done            in   1   burst complete pulse
//  dev_err             in   1   device error pulse
//  err_flag            out  1   sticky error, cleared on next accepted command
//  sectors_done        out  17  sectors fully transferred in current command
// BEHAVIOUR
//  Reset (nRST=0 at edge): state IDLE. All outputs 0: busy, strobes, valids, counters, err_flag, lba/count regs.
//  States: IDLE -> ISSUE -> XFER -> WAIT_DONE -> (ISSUE | IDLE).
//  IDLE: on IDE_command latch LBA/count/nWR. IDE_busy = 1 on the next cycle; clear err_flag and sectors_done.
//   If count = 0, busy is held 1 cycle and the block returns to IDLE with no device command.
//  ISSUE: dev_count = min(remaining, BURST_SECTORS); dev_lba = current LBA; dev_cmd_valid held until ready.
//   On accept: word counter = dev_count*SECTOR_WORDS; go to XFER.
//  XFER write: dev_wvalid = !IDE_w_almost_empty. wfifo_rdreq = dev_wvalid & dev_wready (same cycle).
//   dev_wdata = wfifo_q.
//  XFER read: pause latch set by IDE_r_almost_full, cleared by IDE_r_go_on (set wins if both high).
//   dev_rready = !pause & !IDE_r_almost_full. Each rvalid&rready registers one rfifo push (1-cycle latency).
//  A word moves only on a valid&ready handshake. Each completed SECTOR_WORDS words increments sectors_done.
//  When the word counter reaches 0, go to WAIT_DONE.
//  WAIT_DONE: on dev_done, LBA += burst count (48-bit, wraps mod 2^48); remaining -= burst count.
//   remaining > 0 -> ISSUE. remaining = 0 -> IDLE, busy drops the same edge.
//  dev_done early in XFER (before the word counter reaches 0): treated as an error.
//  dev_err in any non-IDLE state: err_flag=1, drop all valids/readys, go to IDLE, busy = 0 next cycle.
//   Pending words are abandoned.
//  IDE_command while busy: ignored. IDE_command in the same cycle busy falls: ignored.
//  Simultaneous dev_done and dev_err: error wins.
//  Reset mid-transfer: immediate return to the reset state. No FIFO strobes after the reset edge.
// STRUCTURE
//  ide_pkg: state enum; SECTOR_WORDS; NWR_WRITE=0 / NWR_READ=1; LBA_W=48; CNT_W=17.
//  Sub-module ide_chunk_planner: from remaining/LBA/BURST_SECTORS computes next dev_count and the updated LBA.
//  Remaining FSM, word counter and flow gating stay in the top level.
// TESTING
//  1. Write, LBA=0x100, count=3, wfifo full, device always ready.
//     -> one burst (lba 0x100, count 3), 768 pops, busy high ~770 cycles, sectors_done=3.
//  2. Read, count=0x10000, BURST_SECTORS=256.
//     -> 256 bursts, LBAs stepping by 0x100, final LBA+0xFF00 issued, busy falls after the last dev_done.
//  3. Read, rfifo stress: almost_full asserted mid-sector.
//     -> rready low within 1 cycle, stays low until go_on, no lost or duplicated words.
//  4. Write with almost_empty toggling every 5 cycles.
//     -> wvalid tracks !almost_empty exactly; data order preserved vs FIFO contents.
//  5. dev_err during word 40 of burst 2.
//     -> err_flag=1, busy low next cycle, no further strobes; the next command clears err_flag.
//  6. count=0, command while busy, and nRST pulsed mid-XFER.
//     -> 1-cycle busy; second command ignored; all outputs 0 after the reset edge.

Source files
------------

// File: rtl/ide_pkg.sv
// Shared types and constants for the IDE command executor.
package ide_pkg;

    localparam int LBA_W        = 48;
    localparam int CNT_W        = 17;
    localparam int SECTOR_WORDS = 256;

    localparam logic NWR_WRITE = 1'b0;
    localparam logic NWR_READ  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_WAIT_DONE
    } state_t;

endpackage

// File: rtl/ide_chunk_planner.sv
// Sizes the next device burst and the LBA/remaining count after it.
module ide_chunk_planner
    import ide_pkg::*;
#(
    parameter int BURST_SECTORS = 256
) (
    input  logic [CNT_W-1:0] remaining,
    input  logic [LBA_W-1:0] lba,
    output logic [CNT_W-1:0] chunk,
    output logic [LBA_W-1:0] next_lba,
    output logic [CNT_W-1:0] next_remaining
);

    localparam logic [CNT_W-1:0] MAX_CHUNK = CNT_W'(BURST_SECTORS);

    assign chunk          = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
    assign next_lba       = lba + LBA_W'(chunk);
    assign next_remaining = remaining - chunk;

endmodule

// File: rtl/ide_cmd_executor.sv
// Accepts IDE commands, splits them into device bursts and moves
// words between the FIFOs and the device port.
module ide_cmd_executor #(
    parameter int BURST_SECTORS = 256,
    parameter int SECTOR_WORDS  = ide_pkg::SECTOR_WORDS
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     IDE_command,
    input  logic [ide_pkg::LBA_W-1:0] IDE_LBA,
    input  logic [ide_pkg::CNT_W-1:0] IDE_Sec_Count,
    input  logic                     IDE_nWR,
    output logic                     IDE_busy,
    input  logic                     IDE_w_almost_empty,
    input  logic                     IDE_r_almost_full,
    input  logic                     IDE_r_go_on,
    output logic                     wfifo_rdreq,
    input  logic [15:0]              wfifo_q,
    output logic                     rfifo_wrreq,
    output logic [15:0]              rfifo_data,
    output logic                     dev_cmd_valid,
    input  logic                     dev_cmd_ready,
    output logic [ide_pkg::LBA_W-1:0] dev_lba,
    output logic [ide_pkg::CNT_W-1:0] dev_count,
    output logic                     dev_write,
    output logic [15:0]              dev_wdata,
    output logic                     dev_wvalid,
    input  logic                     dev_wready,
    input  logic [15:0]              dev_rdata,
    input  logic                     dev_rvalid,
    output logic                     dev_rready,
    input  logic                     dev_done,
    input  logic                     dev_err,
    output logic                     err_flag,
    output logic [ide_pkg::CNT_W-1:0] sectors_done
);

    import ide_pkg::*;

    localparam int WCW = CNT_W + $clog2(SECTOR_WORDS + 1);
    localparam int SWW = $clog2(SECTOR_WORDS + 1);
    localparam logic [SWW-1:0] LAST_WORD = SWW'(SECTOR_WORDS - 1);

    state_t state, state_n;

    logic [LBA_W-1:0] lba;
    logic [CNT_W-1:0] remaining;
    logic             wr;
    logic [WCW-1:0]   words_left;
    logic [SWW-1:0]   sec_word;
    logic             pause;

    logic [CNT_W-1:0] chunk;
    logic [CNT_W-1:0] next_remaining;
    logic [LBA_W-1:0] next_lba;

    logic accept, fault, cmd_hs, w_hs, r_hs, hs, last_word;

    ide_chunk_planner #(
        .BURST_SECTORS(BURST_SECTORS)
    ) u_planner (
        .remaining     (remaining),
        .lba           (lba),
        .chunk         (chunk),
        .next_lba      (next_lba),
        .next_remaining(next_remaining)
    );

    assign accept    = (state == S_IDLE) && IDE_command;
    // An early dev_done in XFER means the device lost words.
    assign fault     = (state != S_IDLE) &&
                       (dev_err || ((state == S_XFER) && dev_done));
    assign cmd_hs    = dev_cmd_valid && dev_cmd_ready;
    assign w_hs      = dev_wvalid && dev_wready;
    assign r_hs      = dev_rvalid && dev_rready;
    assign hs        = w_hs || r_hs;
    assign last_word = hs && (words_left == WCW'(1));

    assign wfifo_rdreq = w_hs;
    assign dev_wdata   = wfifo_q;
    assign dev_lba     = lba;
    assign dev_write   = wr;

    always_ff @(posedge clk) begin
        if (!nRST) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:      if (IDE_command) state_n = S_ISSUE;
            S_ISSUE: begin
                if (remaining == '0) state_n = S_IDLE;
                else if (cmd_hs)     state_n = S_XFER;
            end
            S_XFER:      if (last_word) state_n = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (dev_done)
                    state_n = (next_remaining == '0) ? S_IDLE : S_ISSUE;
            end
            default:     state_n = S_IDLE;
        endcase
        if (fault) state_n = S_IDLE;
    end

    always_comb begin
        IDE_busy      = (state != S_IDLE);
        dev_cmd_valid = 1'b0;
        dev_count     = '0;
        dev_wvalid    = 1'b0;
        dev_rready    = 1'b0;
        unique case (state)
            S_ISSUE: begin
                dev_cmd_valid = (remaining != '0);
                dev_count     = chunk;
            end
            S_XFER: begin
                if (wr) dev_wvalid = !IDE_w_almost_empty;
                else    dev_rready = !pause && !IDE_r_almost_full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            lba          <= '0;
            remaining    <= '0;
            wr           <= 1'b0;
            words_left   <= '0;
            sec_word     <= '0;
            pause        <= 1'b0;
            err_flag     <= 1'b0;
            sectors_done <= '0;
            rfifo_wrreq  <= 1'b0;
            rfifo_data   <= '0;
        end else begin
            rfifo_wrreq <= r_hs && !fault;
            if (r_hs) rfifo_data <= dev_rdata;

            if (accept) begin
                lba          <= IDE_LBA;
                remaining    <= IDE_Sec_Count;
                wr           <= (IDE_nWR == NWR_WRITE);
                err_flag     <= 1'b0;
                sectors_done <= '0;
                pause        <= 1'b0;
            end else if (state != S_IDLE) begin
                // Set beats clear when both flags arrive together.
                if (IDE_r_almost_full) pause <= 1'b1;
                else if (IDE_r_go_on)  pause <= 1'b0;
            end

            if (fault) err_flag <= 1'b1;

            if ((state == S_ISSUE) && cmd_hs) begin
                words_left <= WCW'(chunk) * WCW'(SECTOR_WORDS);
                sec_word   <= '0;
            end

            if ((state == S_XFER) && hs && !fault) begin
                words_left <= words_left - WCW'(1);
                if (sec_word == LAST_WORD) begin
                    sec_word     <= '0;
                    sectors_done <= sectors_done + CNT_W'(1);
                end else begin
                    sec_word <= sec_word + SWW'(1);
                end
            end

            if ((state == S_WAIT_DONE) && dev_done && !fault) begin
                lba       <= next_lba;
                remaining <= next_remaining;
            end
        end
    end

endmodule
